an_encoder_n29_5x5: RTL and testbench
=====================================

AN_ENCODER_N29_5X5 -- requirements
Module: an_encoder_n29_5x5

Interface
REQ-001 Parameter A, 29, AN-code multiplier; the 5x5 decoder array uses A=29.
REQ-002 Parameter MSG_W, 10, message width.
REQ-003 Parameter CW_W, 14, codeword width.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  in_msg holds a valid message.
REQ-007 in_ready  output  1  block accepts a message this cycle.
REQ-008 in_msg  input  10  message, unsigned.
REQ-009 flush  input  1  close the partial block and pad the remaining positions.
REQ-010 out_valid  output  1  a complete 5x5 codeword block is presented.
REQ-011 out_ready  input  1  the consumer takes the block.
REQ-012 OUT0..OUT24  output  14 each  codewords; OUTk is row k/5, column k%5, row-major order, matching IN0..IN24 of the decoder array.
REQ-013 ovf_mask  output  25  bit k set means message k exceeded the encodable range.

Function
REQ-014 The block SHALL have states FILL and HOLD and a 5-bit index counter idx, range 0..24.
REQ-015 in_ready SHALL equal 1 exactly when state=FILL and rst_n=1.
REQ-016 An accept occurs when in_valid=1 and in_ready=1; the message SHALL be written to slot idx, and idx SHALL increment.
REQ-017 Codeword arithmetic SHALL be cw = 29*m = (m<<4)+(m<<3)+(m<<2)+m, computed at 15-bit width.
REQ-018 If m<=564, slot idx SHALL store cw[13:0] and ovf_mask[idx] SHALL be cleared. The maximum stored value is 16356.
REQ-019 If m>=565, slot idx SHALL store 0 and ovf_mask[idx] SHALL be set.
REQ-020 An accept at idx=24 SHALL set state to HOLD and idx to 0 on the same edge, so out_valid=1 in the next cycle (latency 1 cycle).
REQ-021 In HOLD, OUT0..OUT24, ovf_mask and out_valid SHALL remain stable until out_valid&out_ready.
REQ-022 In HOLD, in_valid and flush SHALL be ignored.
REQ-023 On out_valid&out_ready, the block SHALL return to FILL on that edge; in_ready SHALL be 1 in the next cycle. There is no accept in the same cycle as the handoff, so the minimum block period is 26 cycles.
REQ-024 OUTk and ovf_mask SHALL keep their old values during FILL until overwritten; out_valid=0 SHALL qualify them.
REQ-025 Flush, FILL, idx>0: slots idx..24 SHALL be written to 0 with mask bits cleared, state SHALL go to HOLD, and idx SHALL go to 0 on that edge.
REQ-026 Flush with an accept in the same cycle: the message SHALL be stored at idx, and padding SHALL start at idx+1.
REQ-027 Flush with an accept at idx=24: behaviour SHALL be identical to a normal completion.
REQ-028 Flush in FILL with idx=0 and no accept SHALL be ignored.
REQ-029 Flush at idx=0 together with an accept SHALL store the message in slot 0, pad slots 1..24 and go to HOLD.
REQ-030 Messages SHALL never be dropped or duplicated; in_ready SHALL be 0 whenever the block cannot store.

Reset
REQ-031 rst_n=0 at a clock edge SHALL set state=FILL, idx=0, out_valid=0, all OUTk=0 and ovf_mask=0.
REQ-032 in_ready SHALL be 0 while rst_n=0.
REQ-033 Reset during FILL or HOLD SHALL discard the partial or held block; no output SHALL appear for it.
REQ-034 The first accept after reset release SHALL go to slot 0.

Verification
REQ-035 Reset, then in_msg=k for k=0..24 back-to-back -> out_valid=1 one cycle after the 25th accept; OUTk=29k (OUT1=29, OUT24=696); ovf_mask=0.
REQ-036 Slot 3 message 564, slot 4 message 565, slot 5 message 1023 -> OUT3=16356, OUT4=0, OUT5=0, ovf_mask=25'h0000030.
REQ-037 Full block with out_ready held low for 10 cycles -> outputs stable and in_ready=0 throughout; in_valid pulses are ignored; handoff on the 11th cycle; in_ready=1 next cycle.
REQ-038 Messages 100..106, then flush with no accept -> next cycle out_valid=1, OUT0..OUT6=2900,2929,...,3074, OUT7..OUT24=0, ovf_mask=0.
REQ-039 Reset after 12 accepts -> out_valid stays 0; the next 25 accepts (in_msg=1) yield all OUTk=29 with ovf_mask=0.
REQ-040 in_valid=1 and out_ready=1 continuously for 3 blocks -> out_valid asserts every 26 cycles, with no lost messages (checked by a reference model of 29*m).

Source files
------------

// File: rtl/an_encoder_n29_5x5.sv
// Collects 25 messages into a 5x5 block of AN codewords (cw = 29*m) for the
// matching decoder array. Partial blocks can be closed early with zero padding.
module an_encoder_n29_5x5 #(
    parameter int A     = 29,
    parameter int MSG_W = 10,
    parameter int CW_W  = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MSG_W-1:0] in_msg,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW_W-1:0]  OUT0,
    output logic [CW_W-1:0]  OUT1,
    output logic [CW_W-1:0]  OUT2,
    output logic [CW_W-1:0]  OUT3,
    output logic [CW_W-1:0]  OUT4,
    output logic [CW_W-1:0]  OUT5,
    output logic [CW_W-1:0]  OUT6,
    output logic [CW_W-1:0]  OUT7,
    output logic [CW_W-1:0]  OUT8,
    output logic [CW_W-1:0]  OUT9,
    output logic [CW_W-1:0]  OUT10,
    output logic [CW_W-1:0]  OUT11,
    output logic [CW_W-1:0]  OUT12,
    output logic [CW_W-1:0]  OUT13,
    output logic [CW_W-1:0]  OUT14,
    output logic [CW_W-1:0]  OUT15,
    output logic [CW_W-1:0]  OUT16,
    output logic [CW_W-1:0]  OUT17,
    output logic [CW_W-1:0]  OUT18,
    output logic [CW_W-1:0]  OUT19,
    output logic [CW_W-1:0]  OUT20,
    output logic [CW_W-1:0]  OUT21,
    output logic [CW_W-1:0]  OUT22,
    output logic [CW_W-1:0]  OUT23,
    output logic [CW_W-1:0]  OUT24,
    output logic [24:0]      ovf_mask
);
    localparam int NSLOT = 25;
    localparam int MAX_M = ((1 << CW_W) - 1) / A;

    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    state_t          r_state, w_state_next;
    logic [4:0]      r_idx, w_idx_next;
    logic [CW_W-1:0] r_slot [NSLOT];
    logic [24:0]     r_mask;

    logic            w_accept;
    logic            w_pad_en;
    logic [4:0]      w_pad_start;
    logic [CW_W:0]   w_m_ext;
    logic [CW_W-1:0] w_cw;
    logic            w_ovf;
    logic [24:0]     w_wr;
    logic [24:0]     w_clr;

    assign in_ready  = (r_state == FILL) && rst_n;
    assign out_valid = (r_state == HOLD);
    assign w_accept  = in_valid && in_ready;

    assign w_m_ext = {{(CW_W + 1 - MSG_W){1'b0}}, in_msg};
    assign w_cw    = CW_W'((w_m_ext << 4) + (w_m_ext << 3) + (w_m_ext << 2) + w_m_ext);
    assign w_ovf   = (int'(in_msg) > MAX_M);

    // Padding begins after the slot being written this cycle, if any.
    assign w_pad_start = w_accept ? (r_idx + 5'd1) : r_idx;
    assign w_pad_en    = flush && (r_state == FILL) &&
                         (w_accept ? (r_idx != 5'd24) : (r_idx != 5'd0));

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot_ctl
            assign w_wr[gi]  = w_accept && (r_idx == 5'(gi));
            assign w_clr[gi] = w_pad_en && (5'(gi) >= w_pad_start);
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            FILL: begin
                if ((w_accept && (r_idx == 5'd24)) || w_pad_en) begin
                    w_state_next = HOLD;
                    w_idx_next   = 5'd0;
                end else if (w_accept) begin
                    w_idx_next = r_idx + 5'd1;
                end
            end
            HOLD: begin
                if (out_ready) w_state_next = FILL;
            end
            default: w_state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= FILL;
            r_idx   <= 5'd0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NSLOT; k++) r_slot[k] <= '0;
            r_mask <= '0;
        end else begin
            for (int k = 0; k < NSLOT; k++) begin
                if (w_wr[k]) begin
                    r_slot[k] <= w_ovf ? '0 : w_cw;
                    r_mask[k] <= w_ovf;
                end else if (w_clr[k]) begin
                    r_slot[k] <= '0;
                    r_mask[k] <= 1'b0;
                end
            end
        end
    end

    assign ovf_mask = r_mask;
    assign OUT0  = r_slot[0];
    assign OUT1  = r_slot[1];
    assign OUT2  = r_slot[2];
    assign OUT3  = r_slot[3];
    assign OUT4  = r_slot[4];
    assign OUT5  = r_slot[5];
    assign OUT6  = r_slot[6];
    assign OUT7  = r_slot[7];
    assign OUT8  = r_slot[8];
    assign OUT9  = r_slot[9];
    assign OUT10 = r_slot[10];
    assign OUT11 = r_slot[11];
    assign OUT12 = r_slot[12];
    assign OUT13 = r_slot[13];
    assign OUT14 = r_slot[14];
    assign OUT15 = r_slot[15];
    assign OUT16 = r_slot[16];
    assign OUT17 = r_slot[17];
    assign OUT18 = r_slot[18];
    assign OUT19 = r_slot[19];
    assign OUT20 = r_slot[20];
    assign OUT21 = r_slot[21];
    assign OUT22 = r_slot[22];
    assign OUT23 = r_slot[23];
    assign OUT24 = r_slot[24];
endmodule

// File: tb/tb_an_encoder_n29_5x5.sv
// Randomized and directed checks of the 5x5 AN encoder against a queue-based
// model that builds each block directly from 29*m and the padding rules.
module tb_an_encoder_n29_5x5;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, flush, out_ready;
    logic [9:0]  in_msg;
    logic        in_ready, out_valid;
    logic [13:0] out_w [25];
    logic [24:0] ovf_mask;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    an_encoder_n29_5x5 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_msg(in_msg), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .OUT0(out_w[0]),   .OUT1(out_w[1]),   .OUT2(out_w[2]),   .OUT3(out_w[3]),
        .OUT4(out_w[4]),   .OUT5(out_w[5]),   .OUT6(out_w[6]),   .OUT7(out_w[7]),
        .OUT8(out_w[8]),   .OUT9(out_w[9]),   .OUT10(out_w[10]), .OUT11(out_w[11]),
        .OUT12(out_w[12]), .OUT13(out_w[13]), .OUT14(out_w[14]), .OUT15(out_w[15]),
        .OUT16(out_w[16]), .OUT17(out_w[17]), .OUT18(out_w[18]), .OUT19(out_w[19]),
        .OUT20(out_w[20]), .OUT21(out_w[21]), .OUT22(out_w[22]), .OUT23(out_w[23]),
        .OUT24(out_w[24]), .ovf_mask(ovf_mask)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Reference model: pending messages in a queue, completed block as arrays.
    int          q[$];
    bit          m_hold = 1'b0;
    int          exp_out [25];
    logic [24:0] exp_mask = '0;

    task automatic build_block();
        for (int k = 0; k < 25; k++) begin
            if (k < q.size()) begin
                exp_out[k]  = (q[k] <= 564) ? 29 * q[k] : 0;
                exp_mask[k] = (q[k] > 564);
            end else begin
                exp_out[k]  = 0;
                exp_mask[k] = 1'b0;
            end
        end
        q.delete();
        m_hold = 1'b1;
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_hold = 1'b0;
            for (int k = 0; k < 25; k++) exp_out[k] = 0;
            exp_mask = '0;
        end else if (m_hold) begin
            if (out_ready) m_hold = 1'b0;
        end else begin
            if (in_valid) q.push_back(int'(in_msg));
            if (q.size() == 25 || (flush && q.size() > 0)) build_block();
        end
    end

    // Per-cycle compare at the falling edge, plus block-period tracking.
    int cyc = 0;
    bit prev_valid = 1'b0;
    bit cont_mode = 1'b0;
    int last_rise = -1;
    int rises = 0;
    int blocks = 0;

    always @(negedge clk) begin
        cyc++;
        chk("in_ready", int'(in_ready), int'(rst_n && !m_hold));
        chk("out_valid", int'(out_valid), int'(m_hold));
        if (m_hold && out_valid) begin
            for (int k = 0; k < 25; k++)
                chk($sformatf("OUT%0d", k), int'(out_w[k]), exp_out[k]);
            chk("ovf_mask", int'(ovf_mask), int'(exp_mask));
        end
        if (out_valid && !prev_valid) begin
            blocks++;
            $display("block %0d presented at cycle %0d mask=%h", blocks, cyc, ovf_mask);
            if (cont_mode) begin
                if (last_rise >= 0) chk("block_period", cyc - last_rise, 26);
                last_rise = cyc;
                rises++;
            end
        end
        prev_valid = out_valid;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic handoff();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_msg = '0;
        repeat (3) tick();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_OUT0", int'(out_w[0]), 0);
        chk("rst_ovf_mask", int'(ovf_mask), 0);
        rst_n = 1'b1;
        tick();

        // k = 0..24 back to back, then a 10-cycle stall
        for (int k = 0; k < 25; k++) begin
            in_valid = 1'b1; in_msg = 10'(k);
            tick();
        end
        chk("ramp_valid", int'(out_valid), 1);
        chk("ramp_OUT1", int'(out_w[1]), 29);
        chk("ramp_OUT24", int'(out_w[24]), 696);
        chk("ramp_mask", int'(ovf_mask), 0);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'($urandom_range(0, 1)); in_msg = 10'($urandom_range(0, 1023));
            tick();
        end
        chk("stall_OUT24", int'(out_w[24]), 696);
        handoff();
        chk("after_handoff_ready", int'(in_ready), 1);
        chk("after_handoff_valid", int'(out_valid), 0);

        // overflow boundary
        for (int k = 0; k < 25; k++) begin
            in_valid = 1'b1;
            in_msg = (k == 3) ? 10'd564 : (k == 4) ? 10'd565 : (k == 5) ? 10'd1023
                   : 10'($urandom_range(0, 564));
            tick();
        end
        chk("ovf_OUT3", int'(out_w[3]), 16356);
        chk("ovf_OUT4", int'(out_w[4]), 0);
        chk("ovf_OUT5", int'(out_w[5]), 0);
        chk("ovf_mask_lit", int'(ovf_mask), 32'h30);
        handoff();

        // partial block closed by flush
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1; in_msg = 10'(100 + k);
            tick();
        end
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", int'(out_valid), 1);
        chk("flush_OUT0", int'(out_w[0]), 2900);
        chk("flush_OUT6", int'(out_w[6]), 3074);
        chk("flush_OUT7", int'(out_w[7]), 0);
        chk("flush_mask", int'(ovf_mask), 0);
        handoff();

        // flush at idx 0: alone is ignored, with an accept it closes a 1-message block
        flush = 1'b1;
        tick();
        chk("flush_idle_valid", int'(out_valid), 0);
        in_valid = 1'b1; in_msg = 10'd7;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_acc0_valid", int'(out_valid), 1);
        chk("flush_acc0_OUT0", int'(out_w[0]), 203);
        chk("flush_acc0_OUT1", int'(out_w[1]), 0);
        handoff();

        // flush together with the 25th accept behaves as a normal completion
        for (int k = 0; k < 25; k++) begin
            in_valid = 1'b1; in_msg = 10'($urandom_range(0, 1023)); flush = (k == 24);
            tick();
        end
        flush = 1'b0;
        chk("flush_acc24_valid", int'(out_valid), 1);
        handoff();

        // reset discards a partial block
        for (int k = 0; k < 12; k++) begin
            in_valid = 1'b1; in_msg = 10'd500;
            tick();
        end
        in_valid = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_partial_valid", int'(out_valid), 0);
        for (int k = 0; k < 25; k++) begin
            in_valid = 1'b1; in_msg = 10'd1;
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 25; k++) chk($sformatf("ones_OUT%0d", k), int'(out_w[k]), 29);
        chk("ones_mask", int'(ovf_mask), 0);
        handoff();

        // continuous streaming for three blocks
        last_rise = -1; rises = 0; cont_mode = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 80; c++) begin
            in_valid = 1'b1; in_msg = 10'($urandom_range(0, 1023));
            tick();
        end
        cont_mode = 1'b0;
        chk("stream_blocks", rises, 3);
        in_valid = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // random traffic with occasional flush and reset
        for (int c = 0; c < 2000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_msg    = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(560, 1023))
                                                    : 10'($urandom_range(0, 1023));
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 2) == 0);
            rst_n     = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
